aes_result_collector: RTL and testbench

- Output-side XRTL transactor that carries AES results from HDL to HVL, the counterpart of the input-pipe stimulus path.
- Each cycle, it captures encoder and decoder result words into a result record.
- Records are buffered in a FIFO and serialized MSB-byte-first onto a byte-wide valid/ready stream that feeds the output pipe.
- It reports FIFO overflow and signals end-of-message after a requested flush has fully drained.

---
 rtl/aes_result_collector.sv | 140 ++++++++++++++
 tb/tb_aes_result_collector.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_result_collector.sv
// AES result collector: captures encoder/decoder results into records,
// queues them and streams them MSB-byte-first over a byte valid/ready port.
module aes_result_collector #(
    parameter int FIFO_DEPTH  = 16,
    parameter int STATE_BYTES = 16,
    parameter int REC_BYTES   = 2*STATE_BYTES+1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          enc_valid,
    input  logic [8*STATE_BYTES-1:0]      enc_data,
    input  logic                          dec_valid,
    input  logic [8*STATE_BYTES-1:0]      dec_data,
    input  logic                          flush_req,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_byte,
    output logic                          out_last,
    output logic                          eom,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int REC_BITS = 8*REC_BYTES;
    localparam int SW       = 8*STATE_BYTES;
    localparam int PADW     = REC_BITS - 2*SW - 4;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int IW       = $clog2(REC_BYTES);

    localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(REC_BYTES-1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [REC_BITS-1:0] mem [FIFO_DEPTH];
    logic [REC_BITS-1:0] record;
    logic [REC_BITS-1:0] shiftReg;
    logic [AW-1:0]       wrPtr;
    logic [AW-1:0]       rdPtr;
    logic [IW-1:0]       byteIdx;
    logic [1:0]          state;
    logic [1:0]          nextState;
    logic                flushPend;
    logic                capture;
    logic                push;
    logic                pop;
    logic                xfer;
    logic                lastXfer;
    logic                fifoEmpty;

    // Low pad bits keep the record a whole number of bytes.
    assign record    = {enc_data, dec_data, enc_valid, dec_valid,
                        2'b00, {PADW{1'b0}}};
    assign capture   = enc_valid | dec_valid;
    assign fifoEmpty = (fifo_level == '0);
    assign xfer      = (state == SEND) && out_ready;
    assign lastXfer  = xfer && (byteIdx == LAST_IDX);
    assign push      = capture && ((fifo_level != FULL) || pop);

    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (byteIdx == LAST_IDX);
    assign out_byte  = shiftReg[REC_BITS-1 -: 8];
    assign eom       = (state == DONE);

    always_comb begin
        pop       = 1'b0;
        nextState = state;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    nextState = SEND;
                end else if ((flushPend || flush_req) && !capture) begin
                    nextState = DONE;
                end
            end
            SEND: begin
                if (lastXfer) begin
                    if (!fifoEmpty) begin
                        pop = 1'b1;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr] <= record;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifo_level <= '0;
            shiftReg   <= '0;
            byteIdx    <= '0;
            flushPend  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= nextState;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr    <= rdPtr + 1'b1;
                shiftReg <= mem[rdPtr];
                byteIdx  <= '0;
            end else if (xfer) begin
                shiftReg <= shiftReg << 8;
                byteIdx  <= byteIdx + 1'b1;
            end
            if (capture && !push) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            if (state == DONE) begin
                flushPend <= 1'b0;
            end else if (flush_req) begin
                flushPend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_result_collector.sv
// Directed self-checking bench for aes_result_collector.
module tb_aes_result_collector;

    localparam int RB = 264;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         enc_valid;
    logic [127:0] enc_data;
    logic         dec_valid;
    logic [127:0] dec_data;
    logic         flush_req;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_byte;
    logic         out_last;
    logic         eom;
    logic         overflow;
    logic [15:0]  drop_count;
    logic [4:0]   fifo_level;

    int checks = 0;
    int failures = 0;

    aes_result_collector dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enc_valid  (enc_valid),
        .enc_data   (enc_data),
        .dec_valid  (dec_valid),
        .dec_data   (dec_data),
        .flush_req  (flush_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .eom        (eom),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [RB-1:0] obs,
                         input logic [RB-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [RB-1:0] mkRec(input logic [127:0] e,
                                            input logic [127:0] d,
                                            input logic ev,
                                            input logic dv);
        return {e, d, ev, dv, 6'b000000};
    endfunction

    task automatic capture(input logic [127:0] e, input logic [127:0] d,
                           input logic ev, input logic dv);
        enc_data  = e;
        dec_data  = d;
        enc_valid = ev;
        dec_valid = dv;
        tick();
        enc_valid = 1'b0;
        dec_valid = 1'b0;
    endtask

    // Collect one record with out_ready high; gap = idle cycles before
    // the first byte, bub = idle cycles inside the record.
    task automatic getRec(output logic [RB-1:0] rec, output int gap,
                          output int bub, output int lastBad,
                          output int eoms, output bit tout);
        int n;
        int cyc;
        n = 0; cyc = 0; rec = '0;
        gap = 0; bub = 0; lastBad = 0; eoms = 0;
        out_ready = 1'b1;
        while (n < 33 && cyc < 300) begin
            if (eom) eoms++;
            if (out_valid) begin
                rec = {rec[RB-9:0], out_byte};
                if (out_last != (n == 32)) lastBad++;
                n++;
            end else if (n == 0) begin
                gap++;
            end else begin
                bub++;
            end
            tick();
            cyc++;
        end
        tout = (n < 33);
    endtask

    logic [RB-1:0] expR;
    logic [RB-1:0] got;
    logic [RB-1:0] exp4 [20];
    logic [RB-1:0] expA, expB, expC, expY, expP, expQ;
    logic [7:0]    bytes [33];
    int gap, bub, lastBad, eoms, idx, cyc, bad, sum, vcnt, eomTot;
    bit tout;

    initial begin
        reset_n   = 1'b0;
        enc_valid = 1'b0;
        dec_valid = 1'b0;
        enc_data  = '0;
        dec_data  = '0;
        flush_req = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_eom", eom, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_drops", drop_count, 16'd0);
        check("rst_level", fifo_level, 5'd0);
        check("rst_byte", out_byte, 8'd0);
        reset_n = 1'b1;
        tick();

        // Single capture, latency and byte order
        out_ready = 1'b1;
        expR = mkRec(128'h3925841d02dc09fbdc118597196a0b32,
                     128'h3243f6a8885a308d313198a2e0370734, 1'b1, 1'b1);
        capture(128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 1'b1, 1'b1);
        check("lat_n1", {fifo_level, out_valid}, {5'd1, 1'b0});
        tick();
        check("lat_n2", out_valid, 1'b1);
        for (int i = 0; i < 33; i++) begin
            bytes[i] = out_byte;
            check("t1_byte", {out_valid, out_last, out_byte},
                  {1'b1, (i == 32), expR[RB-1-8*i -: 8]});
            tick();
        end
        check("t1_b0", bytes[0], 8'h39);
        check("t1_b15", bytes[15], 8'h32);
        check("t1_b16", bytes[16], 8'h32);
        check("t1_b31", bytes[31], 8'h34);
        check("t1_b32", bytes[32], 8'hC0);
        check("t1_after", {out_valid, fifo_level}, {1'b0, 5'd0});

        // Backpressure: ready toggles every cycle
        out_ready = 1'b0;
        expR = mkRec(128'h00112233445566778899aabbccddeeff,
                     128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0);
        capture(128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0);
        tick();
        idx = 0; cyc = 0; bad = 0;
        while (idx < 33 && cyc < 200) begin
            if (!(out_valid && out_byte == expR[RB-1-8*idx -: 8] &&
                  out_last == (idx == 32))) bad++;
            out_ready = (cyc % 2 == 1);
            tick();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        check("t2_bad", bad, 0);
        check("t2_count", idx, 33);
        check("t2_after", out_valid, 1'b0);
        check("t2_lastbyte", expR[7:0], 8'h80);

        // Back-to-back records
        expA = mkRec(128'h0f0e0d0c0b0a09080706050403020100,
                     128'hffeeddccbbaa99887766554433221100, 1'b1, 1'b1);
        expB = mkRec(128'hdeadbeefdeadbeefdeadbeefdeadbeef,
                     128'h0, 1'b0, 1'b1);
        expC = mkRec(128'h1, 128'h2, 1'b1, 1'b1);
        capture(128'h0f0e0d0c0b0a09080706050403020100,
                128'hffeeddccbbaa99887766554433221100, 1'b1, 1'b1);
        capture(128'hdeadbeefdeadbeefdeadbeefdeadbeef, 128'h0, 1'b0, 1'b1);
        capture(128'h1, 128'h2, 1'b1, 1'b1);
        check("t3_level", {fifo_level, out_valid}, {5'd2, 1'b1});
        sum = 0;
        getRec(got, gap, bub, lastBad, eoms, tout);
        sum += gap + bub + lastBad + int'(tout);
        check("t3_recA", got, expA);
        getRec(got, gap, bub, lastBad, eoms, tout);
        sum += gap + bub + lastBad + int'(tout);
        check("t3_recB", got, expB);
        check("t3_recB_ends", {got[RB-1 -: 8], got[7:0]}, 16'hde40);
        getRec(got, gap, bub, lastBad, eoms, tout);
        sum += gap + bub + lastBad + int'(tout);
        check("t3_recC", got, expC);
        check("t3_contig", sum, 0);
        check("t3_after", out_valid, 1'b0);

        // Overflow with a stalled record holding the serializer
        out_ready = 1'b0;
        capture(128'hcafe, 128'hf00d, 1'b1, 1'b1);
        tick();
        check("t4_block", {fifo_level, out_valid}, {5'd0, 1'b1});
        for (int k = 0; k < 20; k++) begin
            exp4[k] = mkRec(128'h1000 + 128'(k), {32'(k), 96'h0}, 1'b1, 1'b1);
            capture(128'h1000 + 128'(k), {32'(k), 96'h0}, 1'b1, 1'b1);
            if (k == 15) begin
                check("t4_full", {fifo_level, overflow}, {5'd16, 1'b0});
            end
        end
        check("t4_level", fifo_level, 5'd16);
        check("t4_ovf", overflow, 1'b1);
        check("t4_drops", drop_count, 16'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        check("t4_lastpos", {out_valid, out_last}, 2'b11);
        expY = mkRec(128'h77, 128'h88, 1'b1, 1'b1);
        capture(128'h77, 128'h88, 1'b1, 1'b1);
        check("t4_popfull", {fifo_level, drop_count}, {5'd16, 16'd4});
        sum = 0;
        for (int k = 0; k < 16; k++) begin
            getRec(got, gap, bub, lastBad, eoms, tout);
            sum += gap + bub + lastBad + int'(tout);
            check("t4_rec", got, exp4[k]);
        end
        getRec(got, gap, bub, lastBad, eoms, tout);
        sum += gap + bub + lastBad + int'(tout);
        check("t4_recY", got, expY);
        check("t4_contig", sum, 0);
        check("t4_after", {out_valid, fifo_level, overflow},
              {1'b0, 5'd0, 1'b1});

        // Flush with two records queued; second request while pending
        out_ready = 1'b0;
        expP = mkRec(128'h5, 128'h6, 1'b1, 1'b1);
        expQ = mkRec(128'h7, 128'h8, 1'b0, 1'b1);
        capture(128'h5, 128'h6, 1'b1, 1'b1);
        capture(128'h7, 128'h8, 1'b0, 1'b1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("t5_noeom", eom, 1'b0);
        eomTot = 0;
        getRec(got, gap, bub, lastBad, eoms, tout);
        eomTot += eoms;
        check("t5_recP", got, expP);
        getRec(got, gap, bub, lastBad, eoms, tout);
        eomTot += eoms;
        check("t5_recQ", got, expQ);
        check("t5_early", {eomTot, 1'b0}, {32'd0, eom});
        tick();
        check("t5_eom", eom, 1'b1);
        eomTot = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (eom) eomTot++;
        end
        check("t5_once", eomTot, 0);

        // Flush with empty FIFO and idle serializer
        flush_req = 1'b1;
        check("t5e_pre", eom, 1'b0);
        tick();
        flush_req = 1'b0;
        check("t5e_eom", eom, 1'b1);
        tick();
        check("t5e_post", eom, 1'b0);

        // Reset in the middle of a record
        out_ready = 1'b0;
        expR = mkRec(128'habcdef, 128'h123456, 1'b1, 1'b1);
        capture(128'habcdef, 128'h123456, 1'b1, 1'b1);
        capture(128'h99, 128'h98, 1'b1, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("t6_b10", {out_valid, out_byte}, {1'b1, expR[RB-1-80 -: 8]});
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst", {out_valid, out_last, out_byte, fifo_level, eom},
              {1'b0, 1'b0, 8'd0, 5'd0, 1'b0});
        check("t6_rst_ovf", {overflow, drop_count}, {1'b0, 16'd0});
        tick();
        tick();
        reset_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) vcnt++;
        end
        check("t6_quiet", {vcnt, 27'd0, fifo_level}, {32'd0, 27'd0, 5'd0});
        expR = mkRec(128'h4242, 128'h2424, 1'b0, 1'b1);
        capture(128'h4242, 128'h2424, 1'b0, 1'b1);
        getRec(got, gap, bub, lastBad, eoms, tout);
        check("t6_rec", got, expR);
        check("t6_end", {out_valid, fifo_level}, {1'b0, 5'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
